calc_seq_ctrl: RTL and testbench
================================

// Module: calc_seq_ctrl
// PURPOSE
//  Command sequencer that owns the calculator register file (2 read / 1 write, 8x8).
//  Accepts one op per handshake, reads operands, runs the ALU, writes result back.
//  Sits between the keypad/command decoder and the regfile; sole driver of regwrite/ra1/ra2/wa/wd.
// PARAMETERS
//  WIDTH    8  datapath / register width in bits
//  REGBITS  3  register address width (2**REGBITS registers)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-high reset
//  cmd_valid    in   1        command present
//  cmd_ready    out  1        controller can accept command (IDLE only)
//  cmd_op       in   3        opcode (see BEHAVIOUR)
//  cmd_dst      in   REGBITS  destination register
//  cmd_srca     in   REGBITS  source A register
//  cmd_srcb     in   REGBITS  source B register
//  cmd_imm      in   WIDTH    immediate for LDI
//  rf_regwrite  out  1        regfile write enable
//  rf_ra1       out  REGBITS  regfile read address 1
//  rf_ra2       out  REGBITS  regfile read address 2
//  rf_wa        out  REGBITS  regfile write address
//  rf_wd        out  WIDTH    regfile write data
//  rf_rd1       in   WIDTH    regfile read data 1 (combinational from rf_ra1)
//  rf_rd2       in   WIDTH    regfile read data 2 (combinational from rf_ra2)
//  result       out  WIDTH    last written value, held until next write
//  carry        out  1        carry/borrow of last ADD/SUB; 0 after other ops
//  zero         out  1        result == 0, updated with result
//  done         out  1        one-cycle pulse in the WRITE cycle
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1 (after reset deasserts); rf_regwrite=0; rf_ra1/ra2/wa=0;
//   rf_wd=0; result=0; carry=0; zero=1; done=0. Latched command and operands cleared.
//  Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL1 A, 110 SHR1 A (logical), 111 LDI.
//  FSM IDLE -> READ -> EXEC -> WRITE -> IDLE; LDI: IDLE -> WRITE -> IDLE.
//  IDLE : cmd_ready=1; on cmd_valid latch op/dst/srca/srcb/imm; advance next edge.
//  READ : rf_ra1=srca, rf_ra2=srcb; capture rf_rd1/rf_rd2 into opA/opB at end of cycle.
//  EXEC : ALU on opA/opB -> registered alu_out, carry_next (WIDTH+1-bit add/sub; SUB carry = borrow).
//  WRITE: rf_regwrite=1, rf_wa=dst, rf_wd=alu_out (or imm for LDI); result/zero/carry update
//         on the same edge the regfile writes; done=1 this cycle only.
//  Latency: ALU op 4 cycles accept-to-IDLE (done in cycle 3); LDI 2 cycles (done in cycle 1).
//  Throughput: new command accepted only in IDLE; cmd_valid outside IDLE ignored (no queue).
//  Arithmetic mod 2**WIDTH; shift carry-in 0; shifted-out bit discarded, carry=0.
//  srca==srcb, dst==srca/srcb legal: operands captured in READ, so write-back never affects them.
//  rf_ra1/rf_ra2 hold their last values outside READ; rf_wa/rf_wd meaningful only while rf_regwrite=1.
//  Reset mid-operation: immediate return to IDLE, rf_regwrite drops asynchronously, no partial write.
//  cmd_* inputs sampled only in the accepting IDLE cycle; later changes have no effect.
// STRUCTURE
//  Shared include calc_defs.vh: opcode localparams (OP_ADD..OP_LDI), FSM state encodings
//   (S_IDLE, S_READ, S_EXEC, S_WRITE, 2 bits), WIDTH/REGBITS defaults.
//  Sub-module calc_alu (combinational: op, a, b -> y, carry); FSM, command/operand
//   latches and flag registers live in calc_seq_ctrl.
// TESTING (bench instantiates calc_seq_ctrl + regfile, 10 ns clock)
//  LDI r1,0x05; LDI r2,0x03 -> each done 1 cycle after accept; result 0x05 then 0x03, zero=0.
//  ADD r3,r1,r2 -> done 3 cycles after accept; r3=0x08, carry=0; read back via rf_ra1=3 gives 0x08.
//  LDI r4,0xFF; ADD r5,r4,r1 -> r5=0x04, carry=1; SUB r6,r2,r1 -> r6=0xFE, carry=1 (borrow).
//  XOR r7,r1,r1 -> r7=0x00, zero=1; SHR1 r1,r1 -> r1=0x02 (dst==src), carry=0.
//  cmd_valid held high through ADD -> exactly one accept per IDLE, cmd_ready=0 in READ/EXEC/WRITE.
//  Assert reset during EXEC of ADD r3 -> rf_regwrite never 1, r3 unchanged, outputs at reset values.

Source files
------------

// File: rtl/calc_seq_ctrl_pkg.sv
// Shared definitions for the calculator command sequencer: default sizes,
// opcode and FSM state encodings, and small decode helpers.
package calc_seq_ctrl_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int REGBITS_DEF = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL1 = 3'b101,
    OP_SHR1 = 3'b110,
    OP_LDI  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_t;

  // Only the arithmetic ops report a carry/borrow; everything else clears it.
  function automatic logic uses_carry(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_alu.sv
// Combinational ALU for the calculator: arithmetic is modulo 2**WIDTH,
// SUB reports a borrow in carry, shifts insert 0 and drop the shifted-out bit.
module calc_seq_ctrl_alu
  import calc_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] wide;

  // Evaluate the selected operation; only ADD/SUB drive a carry/borrow.
  always_comb begin
    y     = '0;
    carry = 1'b0;
    wide  = '0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL1: y = {a[WIDTH-2:0], 1'b0};
      OP_SHR1: y = {1'b0, a[WIDTH-1:1]};
      OP_LDI:  y = '0;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Command sequencer owning the calculator register file. Accepts one command
// in IDLE, reads both operands in READ, computes in EXEC and writes the
// result back in WRITE. LDI skips straight from IDLE to WRITE.
module calc_seq_ctrl
  import calc_seq_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REGBITS = REGBITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [REGBITS-1:0] cmd_dst,
  input  logic [REGBITS-1:0] cmd_srca,
  input  logic [REGBITS-1:0] cmd_srcb,
  input  logic [WIDTH-1:0]   cmd_imm,
  output logic               rf_regwrite,
  output logic [REGBITS-1:0] rf_ra1,
  output logic [REGBITS-1:0] rf_ra2,
  output logic [REGBITS-1:0] rf_wa,
  output logic [WIDTH-1:0]   rf_wd,
  input  logic [WIDTH-1:0]   rf_rd1,
  input  logic [WIDTH-1:0]   rf_rd2,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               zero,
  output logic               done
);

  state_t             state;
  state_t             next_state;
  op_t                op;
  logic [REGBITS-1:0] dst;
  logic [WIDTH-1:0]   imm;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_carry;
  logic               accept;

  assign accept = (state == S_IDLE) && cmd_valid;

  calc_seq_ctrl_alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op),
    .a     (opa),
    .b     (opb),
    .y     (alu_y),
    .carry (alu_c)
  );

  // State register; reset forces IDLE immediately, aborting any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic: ALU ops walk READ/EXEC/WRITE, LDI jumps to WRITE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          next_state = (op_t'(cmd_op) == OP_LDI) ? S_WRITE : S_READ;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_READ:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WRITE;
      S_WRITE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Command latch, operand capture, ALU result register and status flags.
  // Read addresses are loaded at accept so they are stable through READ and
  // then hold; LDI leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op        <= OP_ADD;
      dst       <= '0;
      imm       <= '0;
      rf_ra1    <= '0;
      rf_ra2    <= '0;
      opa       <= '0;
      opb       <= '0;
      alu_out   <= '0;
      alu_carry <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op  <= op_t'(cmd_op);
            dst <= cmd_dst;
            imm <= cmd_imm;
            if (op_t'(cmd_op) != OP_LDI) begin
              rf_ra1 <= cmd_srca;
              rf_ra2 <= cmd_srcb;
            end
          end
        end
        S_READ: begin
          opa <= rf_rd1;
          opb <= rf_rd2;
        end
        S_EXEC: begin
          alu_out   <= alu_y;
          alu_carry <= alu_c;
        end
        S_WRITE: begin
          result <= rf_wd;
          zero   <= (rf_wd == '0);
          carry  <= uses_carry(op) ? alu_carry : 1'b0;
        end
        default: begin
          opa <= opa;
        end
      endcase
    end
  end

  // Write port and handshake decode straight from the state register, so the
  // write enable drops the moment reset is asserted.
  assign rf_regwrite = (state == S_WRITE);
  assign done        = (state == S_WRITE);
  assign rf_wa       = dst;
  assign rf_wd       = (op == OP_LDI) ? imm : alu_out;
  assign cmd_ready   = (state == S_IDLE) && !reset;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: table of commands with hand-computed
// results, plus sequences for held cmd_valid and reset during EXEC.
`timescale 1ns/1ps
module tb_calc_seq_ctrl;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] AND_ = 3'd2;
  localparam logic [2:0] OR_  = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4;
  localparam logic [2:0] SHL  = 3'd5;
  localparam logic [2:0] SHR  = 3'd6;
  localparam logic [2:0] LDI  = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst, cmd_srca, cmd_srcb;
  logic [7:0] cmd_imm;
  logic       rf_regwrite;
  logic [2:0] rf_ra1, rf_ra2, rf_wa;
  logic [7:0] rf_wd, rf_rd1, rf_rd2;
  logic [7:0] result;
  logic       carry, zero, done;

  logic [7:0] mem [8];

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] srca;
    logic [2:0] srcb;
    logic [7:0] imm;
    logic [7:0] res;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  calc_seq_ctrl #(.WIDTH(8), .REGBITS(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .rf_regwrite(rf_regwrite), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .result(result), .carry(carry), .zero(zero), .done(done)
  );

  // Register file: synchronous write, combinational reads.
  always_ff @(posedge clk) begin
    if (rf_regwrite) mem[rf_wa] <= rf_wd;
  end
  assign rf_rd1 = mem[rf_ra1];
  assign rf_rd2 = mem[rf_ra2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                              input logic [2:0] sb, input logic [7:0] imm, input logic [7:0] res,
                              input logic c, input logic z);
    vec_t v;
    v.op = op; v.dst = dst; v.srca = sa; v.srcb = sb; v.imm = imm;
    v.res = res; v.c = c; v.z = z;
    v.lat = (op == LDI) ? 1 : 3;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input int idx);
    int  cyc;
    bit  seen;
    string n;
    n = $sformatf("v%0d", idx);
    @(negedge clk);
    cyc = 0;
    while (!cmd_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({n, " ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = v.op; cmd_dst = v.dst; cmd_srca = v.srca; cmd_srcb = v.srcb; cmd_imm = v.imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_dst = 3'($urandom); cmd_srca = 3'($urandom);
    cmd_srcb = 3'($urandom); cmd_imm = 8'($urandom);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({n, " done_seen"}, 32'(seen), 32'd1);
    check({n, " latency"}, 32'(cyc), 32'(v.lat));
    check({n, " regwrite"}, 32'(rf_regwrite), 32'd1);
    check({n, " wa"}, 32'(rf_wa), 32'(v.dst));
    check({n, " wd"}, 32'(rf_wd), 32'(v.res));
    @(negedge clk);
    check({n, " done_pulse"}, 32'(done), 32'd0);
    check({n, " result"}, 32'(result), 32'(v.res));
    check({n, " carry"}, 32'(carry), 32'(v.c));
    check({n, " zero"}, 32'(zero), 32'(v.z));
    check({n, " rf_mem"}, 32'(mem[v.dst]), 32'(v.res));
  endtask

  task automatic check_reset_values(input string n);
    check({n, " ready"}, 32'(cmd_ready), 32'd1);
    check({n, " regwrite"}, 32'(rf_regwrite), 32'd0);
    check({n, " ra1"}, 32'(rf_ra1), 32'd0);
    check({n, " ra2"}, 32'(rf_ra2), 32'd0);
    check({n, " wa"}, 32'(rf_wa), 32'd0);
    check({n, " wd"}, 32'(rf_wd), 32'd0);
    check({n, " result"}, 32'(result), 32'd0);
    check({n, " carry"}, 32'(carry), 32'd0);
    check({n, " zero"}, 32'(zero), 32'd1);
    check({n, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(LDI,  3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0, 1'b0);
    vecs[1]  = mk(LDI,  3'd2, 3'd0, 3'd0, 8'h03, 8'h03, 1'b0, 1'b0);
    vecs[2]  = mk(ADD,  3'd3, 3'd1, 3'd2, 8'h00, 8'h08, 1'b0, 1'b0);
    vecs[3]  = mk(LDI,  3'd4, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    vecs[4]  = mk(ADD,  3'd5, 3'd4, 3'd1, 8'h00, 8'h04, 1'b1, 1'b0);
    vecs[5]  = mk(SUB,  3'd6, 3'd2, 3'd1, 8'h00, 8'hFE, 1'b1, 1'b0);
    vecs[6]  = mk(LDI,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    vecs[7]  = mk(XOR_, 3'd7, 3'd1, 3'd1, 8'h00, 8'h00, 1'b0, 1'b1);
    vecs[8]  = mk(SHR,  3'd1, 3'd1, 3'd0, 8'h00, 8'h02, 1'b0, 1'b0);
    vecs[9]  = mk(AND_, 3'd0, 3'd2, 3'd6, 8'h00, 8'h02, 1'b0, 1'b0);
    vecs[10] = mk(OR_,  3'd0, 3'd2, 3'd1, 8'h00, 8'h03, 1'b0, 1'b0);
    vecs[11] = mk(SHL,  3'd0, 3'd4, 3'd0, 8'h00, 8'hFE, 1'b0, 1'b0);
    vecs[12] = mk(SUB,  3'd0, 3'd1, 3'd1, 8'h00, 8'h00, 1'b0, 1'b1);
    vecs[13] = mk(ADD,  3'd0, 3'd4, 3'd4, 8'h00, 8'hFE, 1'b1, 1'b0);

    reset = 1'b1; cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_dst = 3'd0; cmd_srca = 3'd0; cmd_srcb = 3'd0; cmd_imm = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("reset");

    for (int i = 0; i < 14; i++) run_cmd(vecs[i], i);

    // cmd_valid held through an ADD: one accept, ready low while busy,
    // source changes after accept ignored. r1=02, r2=03 -> r3=05.
    @(negedge clk);
    check("hold ready0", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_dst = 3'd3; cmd_srca = 3'd1; cmd_srcb = 3'd2;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_srca = 3'd4;
        check("hold ra1_read", 32'(rf_ra1), 32'd1);
      end
      check($sformatf("hold ready%0d", k), 32'(cmd_ready), 32'd0);
      check($sformatf("hold done%0d", k), 32'(done), (k == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold ready4", 32'(cmd_ready), 32'd1);
    check("hold result", 32'(result), 32'h05);
    check("hold rf_mem", 32'(mem[3]), 32'h05);
    @(negedge clk);
    check("hold no_second", 32'(done), 32'd0);
    check("hold idle_ready", 32'(cmd_ready), 32'd1);

    // Reset during EXEC of ADD r3,r4,r4: no write, r3 keeps 05.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_dst = 3'd3; cmd_srca = 3'd4; cmd_srcb = 3'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst regwrite_a", 32'(rf_regwrite), 32'd0);
    check("rst ready_in_reset", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("rst regwrite_b", 32'(rf_regwrite), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_values("rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst idle_regwrite%0d", k), 32'(rf_regwrite), 32'd0);
    end
    check("rst r3_kept", 32'(mem[3]), 32'h05);

    run_cmd(mk(LDI, 3'd2, 3'd0, 3'd0, 8'h80, 8'h80, 1'b0, 1'b0), 100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
